ahb_mux_param: RTL and testbench
================================

AHB_MUX_PARAM -- requirements
Module: ahb_mux_param

Interface
REQ-001 Parameter: NSAT, default 4; number of satellite ports, 1..16.
REQ-002 Parameter: BASE[NSAT], default {0x0000_0000, 0x0002_0000, 0x0003_0000, 0x0004_0000}; region base address per satellite.
REQ-003 Parameter: MASK[NSAT], default {0xFFFF_0000, 0xFFFF_FFF0, 0xFFFF_FF00, 0xFFFF_FF00}; region match mask per satellite.
REQ-004 Parameter: TIMEOUT, default 256; stall-cycle limit, 2..65535.
REQ-005 Port: clk  input  1  system clock, rising edge.
REQ-006 Port: nrst  input  1  reset, synchronous, active-low.
REQ-007 Port: abif_to_controller  modport mux_to_controller  -  AHB-Lite controller side (haddr, htrans, hwrite, hsize, hburst, hwdata in; hrdata, hready, hresp out).
REQ-008 Port: abif_to_sat[NSAT]  modport mux_to_satellite array  -  satellite ports; hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready out; hrdata, hreadyout, hresp in.

Function
REQ-009 Address-phase decode SHALL be combinational: satellite i matches when (haddr & MASK[i]) == BASE[i]; lowest index wins on overlap.
REQ-010 hsel[i] SHALL assert only for the matching satellite and only when htrans != IDLE.
REQ-011 haddr, htrans, hwrite, hsize, hburst, hwdata SHALL broadcast to all satellites unmodified; hready to every satellite SHALL equal the controller-side hready.
REQ-012 When hready is high, the data-phase select register (sel_q, with an internal default-satellite code DEF = NSAT) and the htrans_q register SHALL load the address-phase decode (DEF when no match); when hready is low they SHALL hold.
REQ-013 Data-phase return (hrdata, hreadyout-derived hready, hresp) SHALL mux from satellite sel_q; latency from satellite output to controller SHALL be zero cycles.
REQ-014 Internal default satellite, 3-state FSM: IDLE, ERR1, ERR2.
REQ-015 IDLE: sel_q == DEF and htrans_q == NONSEQ/SEQ -> ERR1; otherwise hready=1, hresp=OKAY, hrdata=0.
REQ-016 ERR1: hready=0, hresp=ERROR, next ERR2; ERR2: hready=1, hresp=ERROR, next IDLE.
REQ-017 IDLE or BUSY transfers to an unmapped address SHALL complete zero-wait with OKAY.
REQ-018 Back-to-back unmapped NONSEQ transfers SHALL each receive a full two-cycle ERROR response with no OKAY cycle between them.
REQ-019 The controller SHALL be able to drive IDLE during ERR1; the next address SHALL be sampled at the ERR2 edge per REQ-012.
REQ-020 hrdata for an unselected or default data phase SHALL be 32'h0.

Reset
REQ-021 On nrst low at a rising edge: sel_q=DEF, htrans_q=IDLE, FSM=IDLE, stall counter=0.
REQ-022 During reset and the first cycle after it, controller hready SHALL be 1 and hresp OKAY.
REQ-023 Reset mid-transfer (including in ERR1 or mid-timeout) SHALL abandon the transfer with no further ERROR cycles.

Configuration
REQ-024 Macro AHB_MUX_TIMEOUT_EN: when defined, a 16-bit stall counter SHALL increment each cycle the selected real satellite holds hreadyout low and clear whenever hready is high.
REQ-025 With AHB_MUX_TIMEOUT_EN, on the counter reaching TIMEOUT the mux SHALL override the satellite and drive ERR1 then ERR2 (REQ-016), then set sel_q=DEF and ignore that satellite's hreadyout for the abandoned phase.
REQ-026 Without AHB_MUX_TIMEOUT_EN, no counter SHALL exist and stalls SHALL pass through indefinitely.

Verification
REQ-027 Read at 0x0000_0010 with sat0 hrdata=0xDEADBEEF, hreadyout=1 -> hsel[0]=1 in the address phase; controller hrdata=0xDEADBEEF and hready=1 in the next cycle.
REQ-028 NONSEQ at 0x0005_0000 -> one cycle hready=0/hresp=1, then one cycle hready=1/hresp=1, then OKAY.
REQ-029 Write to 0x0002_0004, then a read from 0x0000_0000 with sat1 stalling 3 cycles -> sel_q holds 1 for 3 cycles; the sat0 address phase completes on the 4th cycle.
REQ-030 IDLE at 0x0009_0000 -> no ERROR; hready=1, hresp=0.
REQ-031 AHB_MUX_TIMEOUT_EN, TIMEOUT=4, sat2 hreadyout stuck at 0 -> ERROR response at stall cycle 4; the next NONSEQ to sat0 completes normally.
REQ-032 nrst asserted during ERR1 -> the cycle after release shows hready=1, hresp=0, FSM=IDLE.

Source files
------------

// File: rtl/ahb_mux_param_if.sv
// AHB-Lite link between the mux and one controller or satellite.
// The mux_to_controller and mux_to_satellite modports give the mux's view of each end.
interface ahb_mux_param_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;

  modport mux_to_controller (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );

  modport mux_to_satellite (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_mux_param.sv
// AHB-Lite decoder and response mux with an internal error-returning default satellite.
// Defining AHB_MUX_TIMEOUT_EN adds a stall counter that aborts hung transfers with ERROR.
module ahb_mux_param #(
  parameter int unsigned NSAT          = 4,
  parameter logic [31:0] BASE [NSAT]   = '{32'h0000_0000, 32'h0002_0000, 32'h0003_0000,
                                           32'h0004_0000},
  parameter logic [31:0] MASK [NSAT]   = '{32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FF00,
                                           32'hFFFF_FF00},
  parameter int unsigned TIMEOUT       = 256
) (
  input logic                        clk,
  input logic                        nrst,
  ahb_mux_param_if.mux_to_controller abif_to_controller,
  ahb_mux_param_if.mux_to_satellite  abif_to_sat [NSAT]
);

  localparam int unsigned   SW  = $clog2(NSAT + 1);
  localparam logic [SW-1:0] DEF = SW'(NSAT);
  localparam logic [1:0]    HtransIdle = 2'b00;

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] dec_sel, sel_q, sel_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hready, hresp;
  logic [31:0]   hrdata;
  logic          err_pend, timeout, found;

  logic [NSAT-1:0] sat_readyout, sat_resp;
  logic [31:0]     sat_rdata [NSAT];

  // Address-phase decode; the first match in index order wins.
  always_comb begin
    dec_sel = DEF;
    found   = 1'b0;
    for (int unsigned i = 0; i < NSAT; i++) begin
      if (!found && ((abif_to_controller.haddr & MASK[i]) == BASE[i])) begin
        dec_sel = SW'(i);
        found   = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NSAT; g++) begin : g_sat
    assign abif_to_sat[g].hsel   = (dec_sel == SW'(g)) &&
                                   (abif_to_controller.htrans != HtransIdle);
    assign abif_to_sat[g].haddr  = abif_to_controller.haddr;
    assign abif_to_sat[g].htrans = abif_to_controller.htrans;
    assign abif_to_sat[g].hwrite = abif_to_controller.hwrite;
    assign abif_to_sat[g].hsize  = abif_to_controller.hsize;
    assign abif_to_sat[g].hburst = abif_to_controller.hburst;
    assign abif_to_sat[g].hwdata = abif_to_controller.hwdata;
    assign abif_to_sat[g].hready = hready;
    assign sat_rdata[g]          = abif_to_sat[g].hrdata;
    assign sat_readyout[g]       = abif_to_sat[g].hreadyout;
    assign sat_resp[g]           = abif_to_sat[g].hresp;
  end

`ifdef AHB_MUX_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        stall;

  assign stall   = (state_q == StIdle) && (sel_q != DEF) && !hready;
  assign timeout = stall && (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!nrst || hready || timeout) begin
      cnt_q <= '0;
    end else if (stall) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // A timeout drops the hung satellite so its hreadyout is ignored from here on.
  always_comb begin
    sel_d    = sel_q;
    htrans_d = htrans_q;
    if (timeout) begin
      sel_d    = DEF;
      htrans_d = HtransIdle;
    end else if (hready) begin
      sel_d    = dec_sel;
      htrans_d = abif_to_controller.htrans;
    end
  end

  // Error is decided as the address phase is accepted, so ERR1 lines up with the data phase.
  assign err_pend = (sel_d == DEF) && htrans_d[1];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= StIdle;
      sel_q    <= DEF;
      htrans_q <= HtransIdle;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      htrans_q <= htrans_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (timeout || err_pend) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = err_pend ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (nrst) begin
      unique case (state_q)
        StErr1: begin
          hready = 1'b0;
          hresp  = 1'b1;
        end
        StErr2: hresp = 1'b1;
        default: begin
          for (int unsigned i = 0; i < NSAT; i++) begin
            if (sel_q == SW'(i)) begin
              hrdata = sat_rdata[i];
              hready = sat_readyout[i];
              hresp  = sat_resp[i];
            end
          end
        end
      endcase
    end
  end

  assign abif_to_controller.hready = hready;
  assign abif_to_controller.hresp  = hresp;
  assign abif_to_controller.hrdata = hrdata;

endmodule

// File: tb/tb_ahb_mux_param.sv
// Directed self-checking bench for ahb_mux_param with the default four-satellite map.
module tb_ahb_mux_param;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10;

  logic clk = 1'b0;
  logic nrst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] s_rdata [4];
  logic        s_ready [4];
  logic        s_resp  [4];
  logic [3:0]  s_hsel;

  always #5 clk = ~clk;

  ahb_mux_param_if ctl_if ();
  ahb_mux_param_if sat_if [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_sat
    assign sat_if[g].hrdata    = s_rdata[g];
    assign sat_if[g].hreadyout = s_ready[g];
    assign sat_if[g].hresp     = s_resp[g];
    assign s_hsel[g]           = sat_if[g].hsel;
  end

  ahb_mux_param #(.TIMEOUT(4)) dut (
    .clk                (clk),
    .nrst               (nrst),
    .abif_to_controller (ctl_if),
    .abif_to_sat        (sat_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans, input logic wr);
    ctl_if.haddr  = addr;
    ctl_if.htrans = trans;
    ctl_if.hwrite = wr;
  endtask

  task automatic expect_resp(input string tag, input logic rdy, input logic resp);
    #1;
    check({tag, ".hready"}, {31'b0, ctl_if.hready}, {31'b0, rdy});
    check({tag, ".hresp"}, {31'b0, ctl_if.hresp}, {31'b0, resp});
  endtask

  initial begin
    s_rdata = '{32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    s_ready = '{1'b1, 1'b1, 1'b1, 1'b1};
    s_resp  = '{1'b0, 1'b0, 1'b0, 1'b0};
    ctl_if.hsize  = 3'b010;
    ctl_if.hburst = 3'b000;
    ctl_if.hwdata = 32'h0;
    drive(32'h0, IDLE, 1'b0);
    nrst = 1'b0;

    // Reset and the first cycle after it
    expect_resp("rst_during", 1'b1, 1'b0);
    cyc();
    cyc();
    nrst = 1'b1;
    expect_resp("rst_after", 1'b1, 1'b0);
    check("rst_hrdata", ctl_if.hrdata, 32'h0);

    // Read from sat0
    drive(32'h0000_0010, NONSEQ, 1'b0);
    #1 check("rd0_hsel", {28'b0, s_hsel}, 32'h1);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    #1 check("rd0_hrdata", ctl_if.hrdata, 32'hDEAD_BEEF);
    check("rd0_idle_hsel", {28'b0, s_hsel}, 32'h0);
    expect_resp("rd0", 1'b1, 1'b0);

    // Decode boundaries
    drive(32'h0002_0004, NONSEQ, 1'b0);
    #1 check("dec_sat1", {28'b0, s_hsel}, 32'h2);
    drive(32'h0003_0080, NONSEQ, 1'b0);
    #1 check("dec_sat2", {28'b0, s_hsel}, 32'h4);
    drive(32'h0002_0010, NONSEQ, 1'b0);
    #1 check("dec_unmapped", {28'b0, s_hsel}, 32'h0);
    drive(32'h0000_FFFF, SEQ_OR_NONSEQ(), 1'b0);
    #1 check("dec_sat0_top", {28'b0, s_hsel}, 32'h1);
    drive(32'h0, IDLE, 1'b0);
    cyc();

    // Unmapped NONSEQ, controller goes IDLE during ERR1
    drive(32'h0005_0000, NONSEQ, 1'b0);
    #1 check("err_hsel", {28'b0, s_hsel}, 32'h0);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    expect_resp("err_c1", 1'b0, 1'b1);
    check("err_hrdata", ctl_if.hrdata, 32'h0);
    cyc();
    expect_resp("err_c2", 1'b1, 1'b1);
    cyc();
    expect_resp("err_c3", 1'b1, 1'b0);

    // IDLE and BUSY to unmapped addresses complete with OKAY
    drive(32'h0009_0000, IDLE, 1'b0);
    cyc();
    expect_resp("idle_unm", 1'b1, 1'b0);
    drive(32'h0009_0000, BUSY, 1'b0);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    expect_resp("busy_unm", 1'b1, 1'b0);
    cyc();

    // Back-to-back unmapped NONSEQ transfers
    drive(32'h0005_0000, NONSEQ, 1'b0);
    cyc();
    drive(32'h0005_0004, NONSEQ, 1'b0);
    expect_resp("b2b_a1", 1'b0, 1'b1);
    cyc();
    expect_resp("b2b_a2", 1'b1, 1'b1);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    expect_resp("b2b_b1", 1'b0, 1'b1);
    cyc();
    expect_resp("b2b_b2", 1'b1, 1'b1);
    cyc();
    expect_resp("b2b_end", 1'b1, 1'b0);

    // Write to sat1 stalling 3 cycles, then a read from sat0
    drive(32'h0002_0004, NONSEQ, 1'b1);
    cyc();
    drive(32'h0000_0000, NONSEQ, 1'b0);
    ctl_if.hwdata = 32'hA5A5_5A5A;
    s_ready[1] = 1'b0;
    expect_resp("wr_stall1", 1'b0, 1'b0);
    check("wr_hsel0", {28'b0, s_hsel}, 32'h1);
    check("wr_hwdata_bc", sat_if[3].hwdata, 32'hA5A5_5A5A);
    check("wr_haddr_bc", sat_if[2].haddr, 32'h0);
    check("wr_sat_hready", {31'b0, sat_if[2].hready}, 32'h0);
    cyc();
    expect_resp("wr_stall2", 1'b0, 1'b0);
    cyc();
    expect_resp("wr_stall3", 1'b0, 1'b0);
    check("wr_sel_hold", ctl_if.hrdata, 32'h1111_1111);
    cyc();
    s_ready[1] = 1'b1;
    expect_resp("wr_done", 1'b1, 1'b0);
    cyc();
    drive(32'h0004_0010, NONSEQ, 1'b0);
    #1 check("rd_after_wr", ctl_if.hrdata, 32'hDEAD_BEEF);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    s_resp[3] = 1'b1;
    expect_resp("sat3_resp", 1'b1, 1'b1);
    check("sat3_hrdata", ctl_if.hrdata, 32'h3333_3333);
    cyc();
    s_resp[3] = 1'b0;

`ifdef AHB_MUX_TIMEOUT_EN
    // sat2 hangs; four stall cycles then ERR1/ERR2, next transfer to sat0 is clean
    drive(32'h0003_0000, NONSEQ, 1'b0);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    s_ready[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      expect_resp($sformatf("to_stall%0d", k), 1'b0, 1'b0);
      cyc();
    end
    expect_resp("to_err1", 1'b0, 1'b1);
    cyc();
    drive(32'h0000_0010, NONSEQ, 1'b0);
    expect_resp("to_err2", 1'b1, 1'b1);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    expect_resp("to_next", 1'b1, 1'b0);
    check("to_next_hrdata", ctl_if.hrdata, 32'hDEAD_BEEF);
    s_ready[2] = 1'b1;
    cyc();
`else
    // Without the timeout a stall passes straight through
    drive(32'h0003_0000, NONSEQ, 1'b0);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    s_ready[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      expect_resp($sformatf("nto_stall%0d", k), 1'b0, 1'b0);
      cyc();
    end
    s_ready[2] = 1'b1;
    expect_resp("nto_done", 1'b1, 1'b0);
    cyc();
`endif

    // Reset during ERR1 abandons the error response
    drive(32'h0005_0000, NONSEQ, 1'b0);
    cyc();
    drive(32'h0, IDLE, 1'b0);
    expect_resp("rerr_err1", 1'b0, 1'b1);
    nrst = 1'b0;
    expect_resp("rerr_in_rst", 1'b1, 1'b0);
    cyc();
    nrst = 1'b1;
    expect_resp("rerr_after", 1'b1, 1'b0);
    cyc();
    expect_resp("rerr_after2", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic [1:0] SEQ_OR_NONSEQ();
    logic [1:0] seq;
    seq = 2'b11;
    return seq;
  endfunction

endmodule
